// File: rtl/e203_csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, field masks
// and mcountinhibit bit positions.
package e203_csr_pkg;

  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [31:0] MCAUSE_MASK  = 32'h8000_001F;
  localparam logic [31:0] MISA_DEFAULT = 32'h4000_1105;

  localparam int unsigned MCNTINH_CY = 0;
  localparam int unsigned MCNTINH_IR = 2;

endpackage

// File: rtl/e203_csr_cnt64.sv
// 64-bit performance counter with halfword software writes that override
// the increment in the same cycle.
module e203_csr_cnt64 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  input  logic        i_inhibit,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_cnt
);

  logic [63:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_wr_lo) begin
      r_cnt <= {r_cnt[63:32], i_wdata};
    end else if (i_wr_hi) begin
      r_cnt <= {i_wdata, r_cnt[31:0]};
    end else if (i_inc && !i_inhibit) begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/e203_exu_csr_file.sv
// Machine-mode CSR file: combinational read/legality decode, write-back,
// trap-state capture and the mcycle/minstret counters.
module e203_exu_csr_file
  import e203_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL  = MISA_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_csr_ena,
  input  logic        i_csr_rd_en,
  input  logic        i_csr_wr_en,
  input  logic [11:0] i_csr_idx,
  input  logic [31:0] i_wbck_csr_dat,
  output logic [31:0] o_read_csr_dat,
  output logic        o_csr_access_ilgl,
  input  logic [31:0] i_core_mhartid,
  input  logic        i_cmt_instret_ena,
  input  logic        i_cmt_trap_ena,
  input  logic [31:0] i_cmt_epc,
  input  logic [31:0] i_cmt_cause,
  input  logic [31:0] i_cmt_badaddr,
  output logic [31:0] o_csr_mtvec_r,
  output logic [31:0] o_csr_epc_r
);

  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic        r_cy, r_ir;
  logic [63:0] w_mcycle, w_minstret;
  logic [31:0] w_rdata;
  logic        w_impl, w_wr;
  logic        w_unused;

  // Read data is only consumed when the access reads; epc bit 0 is forced to 0.
  assign w_unused = ^{i_csr_rd_en, i_cmt_epc[0]};

  always_comb begin
    w_impl  = 1'b1;
    w_rdata = '0;
    case (i_csr_idx)
      CSR_MISA:          w_rdata = MISA_VAL;
      CSR_MTVEC:         w_rdata = r_mtvec;
      CSR_MCOUNTINHIBIT: begin
        w_rdata[MCNTINH_CY] = r_cy;
        w_rdata[MCNTINH_IR] = r_ir;
      end
      CSR_MSCRATCH:      w_rdata = r_mscratch;
      CSR_MEPC:          w_rdata = r_mepc;
      CSR_MCAUSE:        w_rdata = r_mcause;
      CSR_MTVAL:         w_rdata = r_mtval;
      CSR_MCYCLE:        w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:       w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:      w_rdata = w_minstret[31:0];
      CSR_MINSTRETH:     w_rdata = w_minstret[63:32];
      CSR_MVENDORID,
      CSR_MARCHID:       w_rdata = '0;
      CSR_MHARTID:       w_rdata = i_core_mhartid;
      default:           w_impl  = 1'b0;
    endcase
  end

  assign o_read_csr_dat    = w_rdata;
  assign o_csr_access_ilgl = !w_impl || (i_csr_wr_en && (i_csr_idx[11:10] == 2'b11));
  assign w_wr              = i_csr_ena && i_csr_wr_en && !o_csr_access_ilgl;

  // Trap capture outranks a software write to the same register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtvec    <= {MTVEC_RST[31:2], 2'b00};
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_cy       <= 1'b0;
      r_ir       <= 1'b0;
    end else begin
      if (w_wr && (i_csr_idx == CSR_MTVEC)) r_mtvec <= {i_wbck_csr_dat[31:2], 2'b00};
      if (w_wr && (i_csr_idx == CSR_MSCRATCH)) r_mscratch <= i_wbck_csr_dat;
      if (w_wr && (i_csr_idx == CSR_MCOUNTINHIBIT)) begin
        r_cy <= i_wbck_csr_dat[MCNTINH_CY];
        r_ir <= i_wbck_csr_dat[MCNTINH_IR];
      end
      if (i_cmt_trap_ena) begin
        r_mepc   <= {i_cmt_epc[31:1], 1'b0};
        r_mcause <= i_cmt_cause & MCAUSE_MASK;
        r_mtval  <= i_cmt_badaddr;
      end else begin
        if (w_wr && (i_csr_idx == CSR_MEPC))   r_mepc   <= {i_wbck_csr_dat[31:1], 1'b0};
        if (w_wr && (i_csr_idx == CSR_MCAUSE)) r_mcause <= i_wbck_csr_dat & MCAUSE_MASK;
        if (w_wr && (i_csr_idx == CSR_MTVAL))  r_mtval  <= i_wbck_csr_dat;
      end
    end
  end

  e203_csr_cnt64 u_mcycle (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (1'b1),
    .i_inhibit (r_cy),
    .i_wr_lo   (w_wr && (i_csr_idx == CSR_MCYCLE)),
    .i_wr_hi   (w_wr && (i_csr_idx == CSR_MCYCLEH)),
    .i_wdata   (i_wbck_csr_dat),
    .o_cnt     (w_mcycle)
  );

  e203_csr_cnt64 u_minstret (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (i_cmt_instret_ena),
    .i_inhibit (r_ir),
    .i_wr_lo   (w_wr && (i_csr_idx == CSR_MINSTRET)),
    .i_wr_hi   (w_wr && (i_csr_idx == CSR_MINSTRETH)),
    .i_wdata   (i_wbck_csr_dat),
    .o_cnt     (w_minstret)
  );

  assign o_csr_mtvec_r = r_mtvec;
  assign o_csr_epc_r   = r_mepc;

endmodule

// File: tb/tb_e203_exu_csr_file.sv
// Scoreboard bench for the CSR file: expectations are queued as stimulus is
// driven and compared against the outputs on the following falling edge.
module tb_e203_exu_csr_file;
  import e203_csr_pkg::*;

  localparam int K_DATA  = 0;
  localparam int K_ILGL  = 1;
  localparam int K_MTVEC = 2;
  localparam int K_EPC   = 3;

  logic        i_clk, i_rst;
  logic        i_csr_ena, i_csr_rd_en, i_csr_wr_en;
  logic [11:0] i_csr_idx;
  logic [31:0] i_wbck_csr_dat;
  logic [31:0] o_read_csr_dat;
  logic        o_csr_access_ilgl;
  logic [31:0] i_core_mhartid;
  logic        i_cmt_instret_ena, i_cmt_trap_ena;
  logic [31:0] i_cmt_epc, i_cmt_cause, i_cmt_badaddr;
  logic [31:0] o_csr_mtvec_r, o_csr_epc_r;

  e203_exu_csr_file #(
    .MTVEC_RST (32'h8000_0003),
    .MISA_VAL  (32'h4000_1105)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_csr_ena         (i_csr_ena),
    .i_csr_rd_en       (i_csr_rd_en),
    .i_csr_wr_en       (i_csr_wr_en),
    .i_csr_idx         (i_csr_idx),
    .i_wbck_csr_dat    (i_wbck_csr_dat),
    .o_read_csr_dat    (o_read_csr_dat),
    .o_csr_access_ilgl (o_csr_access_ilgl),
    .i_core_mhartid    (i_core_mhartid),
    .i_cmt_instret_ena (i_cmt_instret_ena),
    .i_cmt_trap_ena    (i_cmt_trap_ena),
    .i_cmt_epc         (i_cmt_epc),
    .i_cmt_cause       (i_cmt_cause),
    .i_cmt_badaddr     (i_cmt_badaddr),
    .o_csr_mtvec_r     (o_csr_mtvec_r),
    .o_csr_epc_r       (o_csr_epc_r)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  string       tag_q[$];
  int          kind_q[$];
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input string tag, input logic [31:0] exp);
    kind_q.push_back(kind);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  always @(negedge i_clk) begin
    while (exp_q.size() > 0) begin
      int          k;
      string       t;
      logic [31:0] e;
      logic [31:0] o;
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      case (k)
        K_DATA:  o = o_read_csr_dat;
        K_ILGL:  o = {31'b0, o_csr_access_ilgl};
        K_MTVEC: o = o_csr_mtvec_r;
        default: o = o_csr_epc_r;
      endcase
      check_eq(t, o, e);
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
    i_csr_ena         = 1'b0;
    i_csr_rd_en       = 1'b0;
    i_csr_wr_en       = 1'b0;
    i_csr_idx         = 12'h000;
    i_cmt_trap_ena    = 1'b0;
    i_cmt_instret_ena = 1'b0;
  endtask

  task automatic wr(input logic [11:0] idx, input logic [31:0] dat);
    cyc();
    i_csr_ena      = 1'b1;
    i_csr_wr_en    = 1'b1;
    i_csr_idx      = idx;
    i_wbck_csr_dat = dat;
  endtask

  task automatic rd(input logic [11:0] idx, input logic [31:0] exp, input string tag);
    cyc();
    i_csr_ena   = 1'b1;
    i_csr_rd_en = 1'b1;
    i_csr_idx   = idx;
    push(K_DATA, tag, exp);
    push(K_ILGL, {tag, "_ilgl"}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_csr_ena = 1'b0; i_csr_rd_en = 1'b0; i_csr_wr_en = 1'b0;
    i_csr_idx = '0; i_wbck_csr_dat = '0; i_core_mhartid = 32'h0000_00A5;
    i_cmt_instret_ena = 1'b0; i_cmt_trap_ena = 1'b0;
    i_cmt_epc = '0; i_cmt_cause = '0; i_cmt_badaddr = '0;
    repeat (3) @(posedge i_clk);

    // Reset state and first counter values
    cyc();
    i_rst = 1'b0;
    i_csr_idx = CSR_MCYCLE;
    push(K_DATA, "mcycle_first", 32'd0);
    push(K_MTVEC, "mtvec_rst", 32'h8000_0000);
    push(K_EPC, "epc_rst", 32'd0);
    rd(CSR_MCYCLE, 32'd1, "mcycle_second");
    rd(CSR_MSCRATCH, 32'd0, "mscratch_rst");
    rd(CSR_MISA, 32'h4000_1105, "misa");

    // Plain writes and field masking
    wr(CSR_MSCRATCH, 32'hDEAD_BEEF);
    rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "mscratch_wr");
    wr(CSR_MEPC, 32'h0000_1235);
    rd(CSR_MEPC, 32'h0000_1234, "mepc_wr");
    push(K_EPC, "epc_out", 32'h0000_1234);
    wr(CSR_MTVEC, 32'h0000_1003);
    rd(CSR_MTVEC, 32'h0000_1000, "mtvec_wr");
    push(K_MTVEC, "mtvec_out", 32'h0000_1000);
    wr(CSR_MISA, 32'h0);
    push(K_ILGL, "misa_wr_legal", 32'd0);
    rd(CSR_MISA, 32'h4000_1105, "misa_warl");
    wr(CSR_MCAUSE, 32'hFFFF_FFFF);
    rd(CSR_MCAUSE, 32'h8000_001F, "mcause_mask");

    // Low-half carry into high half, then write-over-increment
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCYCLEH, 32'h0);
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_preset");
    rd(CSR_MCYCLE, 32'h0, "mcycle_carry_lo");
    rd(CSR_MCYCLEH, 32'h1, "mcycle_carry_hi");
    wr(CSR_MCYCLE, 32'd5);
    rd(CSR_MCYCLE, 32'd5, "mcycle_wr5");
    rd(CSR_MCYCLE, 32'd6, "mcycle_wr5_inc");
    rd(CSR_MCYCLEH, 32'd1, "mcycleh_kept");
    // Full 64-bit wrap
    wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "wrap_pre");
    rd(CSR_MCYCLE, 32'h0, "wrap_lo");
    rd(CSR_MCYCLEH, 32'h0, "wrap_hi");

    // minstret counting, inhibit and resume
    cyc(); i_cmt_instret_ena = 1'b1;
    cyc(); i_cmt_instret_ena = 1'b1;
    rd(CSR_MINSTRET, 32'd2, "minstret_2");
    wr(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
    wr(CSR_MCYCLE, 32'd100);
    for (int i = 0; i < 3; i++) begin
      rd(CSR_MCYCLE, 32'd100, "mcycle_inhibited");
      i_cmt_instret_ena = 1'b1;
    end
    rd(CSR_MINSTRET, 32'd2, "minstret_inhibited");
    rd(CSR_MCOUNTINHIBIT, 32'h5, "mcountinhibit_mask");
    wr(CSR_MCOUNTINHIBIT, 32'h0);
    rd(CSR_MCYCLE, 32'd100, "mcycle_resume0");
    i_cmt_instret_ena = 1'b1;
    rd(CSR_MCYCLE, 32'd101, "mcycle_resume1");
    rd(CSR_MINSTRET, 32'd3, "minstret_resume");

    // Trap vs. software write on the same register
    wr(CSR_MEPC, 32'h0000_0200);
    i_cmt_trap_ena = 1'b1; i_cmt_epc = 32'h0000_0100;
    i_cmt_cause = 32'hFFFF_FFFF; i_cmt_badaddr = 32'hCAFE_0001;
    rd(CSR_MEPC, 32'h0000_0100, "trap_mepc");
    push(K_EPC, "trap_epc_out", 32'h0000_0100);
    rd(CSR_MCAUSE, 32'h8000_001F, "trap_mcause");
    rd(CSR_MTVAL, 32'hCAFE_0001, "trap_mtval");
    wr(CSR_MSCRATCH, 32'h0000_1111);
    i_cmt_trap_ena = 1'b1; i_cmt_epc = 32'h0000_0301;
    i_cmt_cause = 32'h8000_0007; i_cmt_badaddr = 32'h0;
    rd(CSR_MSCRATCH, 32'h0000_1111, "trap_other_wr");
    rd(CSR_MEPC, 32'h0000_0300, "trap_mepc_odd");
    rd(CSR_MCAUSE, 32'h8000_0007, "trap_mcause2");

    // Legality
    wr(CSR_MHARTID, 32'hFFFF_FFFF);
    push(K_ILGL, "wr_mhartid", 32'd1);
    wr(12'h7C0, 32'h1234_5678);
    push(K_ILGL, "wr_7c0", 32'd1);
    cyc(); i_csr_idx = 12'h7C0; i_csr_rd_en = 1'b1;
    push(K_ILGL, "rd_7c0_noena", 32'd1);
    push(K_DATA, "rd_7c0_data", 32'd0);
    cyc(); i_csr_idx = CSR_MVENDORID; i_csr_wr_en = 1'b1;
    push(K_ILGL, "wr_mvendorid_noena", 32'd1);
    rd(CSR_MHARTID, 32'h0000_00A5, "rd_mhartid");
    rd(CSR_MSCRATCH, 32'h0000_1111, "mscratch_after_ilgl");
    wr(12'hF11, 32'h1);
    rd(CSR_MVENDORID, 32'h0, "mvendorid");

    // Reset beats write, trap and increment in the same cycle
    wr(CSR_MSCRATCH, 32'h0000_0999);
    i_rst = 1'b1; i_cmt_trap_ena = 1'b1; i_cmt_epc = 32'h0000_0444;
    cyc();
    i_rst = 1'b0;
    i_csr_idx = CSR_MCYCLE;
    push(K_DATA, "mcycle_after_rst", 32'd0);
    push(K_EPC, "epc_after_rst", 32'd0);
    push(K_MTVEC, "mtvec_after_rst", 32'h8000_0000);
    rd(CSR_MSCRATCH, 32'd0, "mscratch_after_rst");
    rd(CSR_MCOUNTINHIBIT, 32'd0, "mcntinh_after_rst");

    cyc();
    @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e203_exu_csr_file.md
# e203_exu_csr_file

Machine-mode CSR register file directly downstream of the ALU CSR-control stage. It supplies combinational read data and an illegal-access flag for the CSR index presented on the CSR bus. It commits write-back data on the cycle the access is enabled. It also maintains the 64-bit cycle and instret counters and takes trap-state updates from the commit unit.

## Interface
Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored)
- MISA_VAL, 32'h4000_1105, read-only misa value (RV32IMAC)

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- csr_ena  in  1  CSR access fires this cycle (handshake already completed upstream)
- csr_rd_en  in  1  access reads the CSR
- csr_wr_en  in  1  access writes the CSR
- csr_idx  in  12  CSR address
- wbck_csr_dat  in  32  data to write
- read_csr_dat  out  32  combinational read data for csr_idx
- csr_access_ilgl  out  1  combinational illegal-access flag
- core_mhartid  in  32  static hart ID
- cmt_instret_ena  in  1  one instruction retired this cycle
- cmt_trap_ena  in  1  trap taken this cycle; loads mepc, mcause and mtval
- cmt_epc  in  32  trap PC
- cmt_cause  in  32  trap cause
- cmt_badaddr  in  32  trap value
- csr_mtvec_r  out  32  current mtvec
- csr_epc_r  out  32  current mepc

## Operation
Implemented CSRs:
- misa 0x301: read-only MISA_VAL; writes are legal and ignored (WARL).
- mtvec 0x305: bits [1:0] read 0 (direct mode).
- mcountinhibit 0x320: bit 0 = CY, bit 2 = IR; all other bits read 0.
- mscratch 0x340: full 32 bits.
- mepc 0x341: bit 0 reads 0.
- mcause 0x342: bits 31 and [4:0] implemented; others read 0.
- mtval 0x343: full 32 bits.
- mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- mvendorid 0xF11 and marchid 0xF12 read 0; mhartid 0xF14 reads core_mhartid.

Illegal access:
- csr_access_ilgl = index not implemented, or (csr_wr_en and csr_idx[11:10]==2'b11).
- The flag is evaluated independently of csr_ena.
- An illegal access changes no state.
- read_csr_dat returns 0 for unimplemented indices.

Writes:
- A write occurs on the rising edge when csr_ena & csr_wr_en & ~csr_access_ilgl.

Counters:
- mcycle increments every cycle unless CY=1.
- minstret increments on cmt_instret_ena unless IR=1.
- Both wrap from 2^64-1 to 0.
- Writing mcycle replaces [31:0] and keeps [63:32]; mcycleh replaces [63:32] and keeps [31:0].
- A software write to either half takes priority over that cycle's increment; the whole counter holds the written value with no increment.

Trap updates:
- cmt_trap_ena loads mepc={cmt_epc[31:1],0}, mcause (masked) and mtval.
- If a CSR write targets the same register in the same cycle, the trap update wins; writes to other registers still proceed.

Reset:
- All registers clear to 0, except mtvec = {MTVEC_RST[31:2],2'b00}.
- csr_mtvec_r and csr_epc_r reflect the registers, so they reset to {MTVEC_RST[31:2],2'b00} and 0.

## Timing
- Read is zero-latency: read_csr_dat is combinational from csr_idx and returns the pre-edge value.
- A counter read returns the value before this cycle's increment.
- Writes and trap updates are visible on read_csr_dat the cycle after the edge.
- csr_mtvec_r and csr_epc_r are registered outputs with no added latency.
- Reset mid-operation: reset takes priority over write, trap and increment in the same cycle. The counters read 0 in the first cycle after reset deasserts.
- No internal stalls: the block never back-pressures, and there is no ready output.

## Structure
- Package e203_csr_pkg holds:
  - 12-bit address constants for every implemented CSR
  - MCAUSE_MASK = 32'h8000_001F
  - default MISA value
  - mcountinhibit bit positions (CY=0, IR=2)
- Sub-module e203_csr_cnt64, instantiated twice (mcycle, minstret):
  - 64-bit counter with inc, inhibit, wr_lo, wr_hi, wdata
  - write-over-increment priority
  - synchronous active-high reset
- Top level: address decode, read mux, legality logic, trap/write priority.

## Test plan
- Reset with MTVEC_RST=32'h8000_0003 -> csr_mtvec_r=32'h8000_0000; mcycle reads 0 the first cycle after reset and 1 the next.
- Write mscratch=32'hDEAD_BEEF, then read -> 32'hDEAD_BEEF; write mepc=32'h1235 -> reads 32'h1234.
- mcycle preset to 32'hFFFF_FFFF with mcycleh=0, CY=0 -> after 1 cycle mcycle=0 and mcycleh=1; write mcycle=5 -> next-cycle read 5 (no increment that cycle).
- Set mcountinhibit=32'h5, pulse cmt_instret_ena 3 cycles -> minstret and mcycle unchanged; clear it -> both resume.
- Same cycle: cmt_trap_ena with cmt_epc=32'h100 and CSR write mepc=32'h200 -> mepc=32'h100; mcause write of 32'hFFFF_FFFF -> reads 32'h8000_001F.
- Write to 0xF14, or access to 0x7C0 -> csr_access_ilgl=1 and no state change; read 0xF14 -> core_mhartid with ilgl=0.
